mem_ws: RTL and testbench
=========================

MEM_WS -- requirements
Module: mem_ws

Interface
REQ-001 Parameter DataWidth, default 32, data bus width in bits; SHALL be a multiple of 8.
REQ-002 Parameter AddrWidth, default 24, word-address width.
REQ-003 Parameter Words, default 4096, number of implemented words; SHALL be at most 2**AddrWidth.
REQ-004 Parameter WaitStates, default 2, extra access cycles; legal range 0..15.
REQ-005 Port clk, input, 1, sole clock; all state changes on rising edge.
REQ-006 Port rst, input, 1, reset, asynchronous, active-high.
REQ-007 Port MemReq, input, 1, request strobe.
REQ-008 Port RdWrBar, input, 1, 1 = read, 0 = write.
REQ-009 Port Address, input, AddrWidth, word address.
REQ-010 Port DataIn, input, DataWidth, write data.
REQ-011 Port ByteEn, input, DataWidth/8, write byte lanes; bit i enables DataIn[8i+7:8i].
REQ-012 Port Ready, output, 1, registered one-cycle completion pulse.
REQ-013 Port DataOut, output, DataWidth, registered read data.
REQ-014 Port AddrErr, output, 1, registered error flag, valid only with Ready.

Function
REQ-015 FSM states: IDLE, BUSY, RESP; Ready is 1 only in RESP.
REQ-016 IDLE or RESP with MemReq=1 at an edge: request accepted; Address, DataIn, ByteEn and RdWrBar captured; wait counter loaded with WaitStates; next state BUSY.
REQ-017 RESP with MemReq=0 -> IDLE; IDLE with MemReq=0 -> stay IDLE.
REQ-018 BUSY, counter != 0: decrement by 1 and stay in BUSY.
REQ-019 BUSY, counter == 0: perform the access, go to RESP, set Ready=1 at the same edge.
REQ-020 Latency: accept at edge N -> Ready high in the cycle following edge N+WaitStates+1; peak throughput one access per WaitStates+2 cycles.
REQ-021 Inputs are ignored while in BUSY; the captured copies govern the access.
REQ-022 Requester SHALL drop MemReq in the Ready cycle unless it is issuing a new request; MemReq=1 in the Ready cycle is a new request.
REQ-023 Read: DataOut <= Mem[captured Address] at the completion edge; DataOut holds until the next read completion.
REQ-024 Write: at the completion edge, only lanes with ByteEn=1 are updated; ByteEn=0 is a legal no-op; DataOut is unchanged.
REQ-025 Captured Address >= Words: no array write; a read returns DataOut=0; AddrErr=1 for the Ready cycle; otherwise AddrErr=0.
REQ-026 A read issued after a completed write to the same word SHALL return the merged written data.
REQ-027 WaitStates=0: BUSY is occupied for exactly 1 cycle.

Reset
REQ-028 rst=1 forces, asynchronously: state IDLE, counter 0, Ready 0, AddrErr 0, DataOut 0.
REQ-029 Reset during BUSY aborts the access: no array write occurs and no Ready is issued.
REQ-030 Array contents are not reset.

Structure
REQ-031 A shared package mem_pkg SHALL hold the FSM state encoding and the default constants (DataWidth, AddrWidth, Words, WaitStates).
REQ-032 The storage array with byte-lane write is one sub-module, mem_array_be.
REQ-033 The block is a single clock domain with no combinational path from input to output.

Verification
REQ-034 Write 0xDEADBEEF, ByteEn=0xF, addr 0x10; then read 0x10 with WaitStates=2 -> Ready 3 cycles after each accept; DataOut=0xDEADBEEF; AddrErr=0.
REQ-035 Write 0x000000AA to addr 0x10 with ByteEn=0x1 over 0xDEADBEEF; then read -> DataOut=0xDEADBEAA.
REQ-036 Read addr 4096 (Words=4096) -> Ready pulse with AddrErr=1 and DataOut=0; a following read of 0 returns the prior contents of word 0.
REQ-037 Back-to-back: MemReq held high across Ready for 3 reads of addrs 1, 2, 3 -> Ready every WaitStates+2 cycles; data returned in order.
REQ-038 Assert rst mid-BUSY during a write of 0x12345678 to addr 5 -> Ready stays 0; a later read of addr 5 returns the old value.
REQ-039 WaitStates=0 build: read accepted at edge N -> Ready high after edge N+1, one cycle wide.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the wait-stated memory block.
// Holds the FSM state encoding, the default build constants and a helper
// that sizes the word index of the storage array.
package mem_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_ADDR_WIDTH  = 24;
    localparam int unsigned DEF_WORDS       = 4096;
    localparam int unsigned DEF_WAIT_STATES = 2;
    localparam int unsigned CNT_WIDTH       = 4;   // holds wait states 0..15

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Index width for an array of 'words' entries (at least one bit).
    function automatic int unsigned idx_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/mem_ws_if.sv
// Request/response bus of the wait-stated memory.
// master: MemReq, RdWrBar, Address, DataIn, ByteEn out; Ready, DataOut, AddrErr in.
// slave : the mirror image, used by mem_ws.
interface mem_ws_if
    import mem_pkg::*;
#(
    parameter int unsigned DataWidth = DEF_DATA_WIDTH,
    parameter int unsigned AddrWidth = DEF_ADDR_WIDTH
) ();

    logic                   MemReq;
    logic                   RdWrBar;
    logic [AddrWidth-1:0]   Address;
    logic [DataWidth-1:0]   DataIn;
    logic [DataWidth/8-1:0] ByteEn;
    logic                   Ready;
    logic [DataWidth-1:0]   DataOut;
    logic                   AddrErr;

    modport master (
        output MemReq, RdWrBar, Address, DataIn, ByteEn,
        input  Ready, DataOut, AddrErr
    );

    modport slave (
        input  MemReq, RdWrBar, Address, DataIn, ByteEn,
        output Ready, DataOut, AddrErr
    );

endinterface

// File: rtl/mem_array_be.sv
// Word-organised storage with per-byte-lane write enables.
// Ports: clk; i_we write strobe; i_be lane enables; i_idx word index;
//        i_wdata write data; o_rdata_c combinational read of word i_idx.
// Contents are deliberately not reset.
module mem_array_be #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Words     = 4096,
    parameter int unsigned IdxWidth  = 12
) (
    input  logic                   clk,
    input  logic                   i_we,
    input  logic [DataWidth/8-1:0] i_be,
    input  logic [IdxWidth-1:0]    i_idx,
    input  logic [DataWidth-1:0]   i_wdata,
    output logic [DataWidth-1:0]   o_rdata_c
);

    localparam int unsigned Lanes = DataWidth / 8;

    logic [DataWidth-1:0] r_mem [Words];

    // Byte-lane merge write
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < Lanes; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata_c = r_mem[i_idx];

endmodule

// File: rtl/mem_ws.sv
// Wait-stated single-port memory with request/Ready handshake.
// Ports: clk; rst (async, active-high); bus (mem_ws_if.slave) carrying
//        MemReq/RdWrBar/Address/DataIn/ByteEn in and Ready/DataOut/AddrErr out.
// A request is captured in IDLE or RESP, held for WaitStates extra cycles in
// BUSY, then completed with a one-cycle Ready pulse in RESP.
module mem_ws
    import mem_pkg::*;
#(
    parameter int unsigned DataWidth  = DEF_DATA_WIDTH,
    parameter int unsigned AddrWidth  = DEF_ADDR_WIDTH,
    parameter int unsigned Words      = DEF_WORDS,
    parameter int unsigned WaitStates = DEF_WAIT_STATES
) (
    input  logic     clk,
    input  logic     rst,
    mem_ws_if.slave  bus
);

    localparam int unsigned Lanes    = DataWidth / 8;
    localparam int unsigned IdxWidth = idx_width(Words);

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_rd;
    logic [AddrWidth-1:0]   r_addr;
    logic [DataWidth-1:0]   r_wdata;
    logic [Lanes-1:0]       r_be;
    logic                   r_ready;
    logic                   r_err;
    logic [DataWidth-1:0]   r_dout;

    logic                   w_in_range;
    logic                   w_done;
    logic [DataWidth-1:0]   w_rdata;

    // One extra bit so Words == 2**AddrWidth compares correctly
    assign w_in_range = {1'b0, r_addr} < (AddrWidth + 1)'(Words);
    // Completion edge; drops immediately if reset aborts the access
    assign w_done     = (r_state == ST_BUSY) && (r_cnt == '0);

    mem_array_be #(
        .DataWidth (DataWidth),
        .Words     (Words),
        .IdxWidth  (IdxWidth)
    ) u_array (
        .clk       (clk),
        .i_we      (w_done && !r_rd && w_in_range),
        .i_be      (r_be),
        .i_idx     (r_addr[IdxWidth-1:0]),
        .i_wdata   (r_wdata),
        .o_rdata_c (w_rdata)
    );

    // Control FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rd    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (bus.MemReq) begin
                        r_rd    <= bus.RdWrBar;
                        r_addr  <= bus.Address;
                        r_wdata <= bus.DataIn;
                        r_be    <= bus.ByteEn;
                        r_cnt   <= CNT_WIDTH'(WaitStates);
                        r_state <= ST_BUSY;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_WIDTH'(1);
                    end else begin
                        r_state <= ST_RESP;
                        r_ready <= 1'b1;
                        r_err   <= !w_in_range;
                        if (r_rd) begin
                            r_dout <= w_in_range ? w_rdata : '0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.Ready   = r_ready;
    assign bus.AddrErr = r_err;
    assign bus.DataOut = r_dout;

endmodule

// File: tb/tb_mem_ws.sv
// Scoreboard bench for mem_ws: one DUT with WaitStates=2, one with WaitStates=0.
module tb_mem_ws;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        q_exp [2][$];
    logic [31:0] last_rd [2];

    mem_ws_if #(.DataWidth(32), .AddrWidth(24)) bus  ();
    mem_ws_if #(.DataWidth(32), .AddrWidth(24)) bus0 ();

    mem_ws #(.DataWidth(32), .AddrWidth(24), .Words(4096), .WaitStates(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_ws #(.DataWidth(32), .AddrWidth(24), .Words(4096), .WaitStates(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? bus0.Ready : bus.Ready;
    endfunction

    task automatic drive(input bit sel, input logic req, input logic rd, input logic [23:0] addr,
                         input logic [31:0] din, input logic [3:0] be);
        if (sel) begin
            bus0.MemReq = req; bus0.RdWrBar = rd; bus0.Address = addr; bus0.DataIn = din; bus0.ByteEn = be;
        end else begin
            bus.MemReq = req; bus.RdWrBar = rd; bus.Address = addr; bus.DataIn = din; bus.ByteEn = be;
        end
    endtask

    // Called at a negedge just before the accepting edge
    task automatic push_exp(input bit sel, input logic rd, input logic [31:0] rdata, input logic err);
        exp_t e;
        int   ws;
        ws = sel ? 0 : 2;
        if (rd) last_rd[sel] = rdata;
        e.data = last_rd[sel];
        e.err  = err;
        e.cyc  = cyc + 1 + ws + 1;
        q_exp[sel].push_back(e);
    endtask

    task automatic wait_ready(input bit sel, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy(sel) && n < 40);
        if (!rdy(sel)) check({name, "_timeout"}, 32'(rdy(sel)), 32'd1);
    endtask

    // Single access; inputs are scrambled while the DUT is busy
    task automatic op(input bit sel, input logic rd, input logic [23:0] addr, input logic [31:0] din,
                      input logic [3:0] be, input logic [31:0] rdata, input logic err);
        @(negedge clk);
        drive(sel, 1'b1, rd, addr, din, be);
        push_exp(sel, rd, rdata, err);
        @(negedge clk);
        drive(sel, 1'b0, 1'($urandom), 24'($urandom), $urandom, 4'($urandom));
        wait_ready(sel, "op");
    endtask

    // Scoreboard monitors: compare each Ready pulse with the oldest expectation
    task automatic monitor(input bit sel, input logic [31:0] dout, input logic err);
        exp_t e;
        if (q_exp[sel].size() == 0) begin
            check(sel ? "ws0_unexpected_ready" : "ws2_unexpected_ready", 32'd1, 32'd0);
        end else begin
            e = q_exp[sel].pop_front();
            check(sel ? "ws0_data" : "ws2_data", dout, e.data);
            check(sel ? "ws0_err" : "ws2_err", 32'(err), 32'(e.err));
            check(sel ? "ws0_ready_cycle" : "ws2_ready_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    always @(negedge clk) if (!rst && bus.Ready)  monitor(1'b0, bus.DataOut, bus.AddrErr);
    always @(negedge clk) if (!rst && bus0.Ready) monitor(1'b1, bus0.DataOut, bus0.AddrErr);

    initial begin
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        check("reset_ready",   32'(bus.Ready),   32'd0);
        check("reset_err",     32'(bus.AddrErr), 32'd0);
        check("reset_dout",    bus.DataOut,      32'h0);
        check("reset_dout_ws0", bus0.DataOut,    32'h0);
        rst = 1'b0;

        // Full write then read, then single-lane merge, then no-op write
        op(0, 0, 24'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0);
        op(0, 1, 24'h10, 32'h0,        4'h0, 32'hDEADBEEF, 0);
        op(0, 0, 24'h10, 32'h000000AA, 4'h1, 32'h0, 0);
        op(0, 1, 24'h10, 32'h0,        4'h0, 32'hDEADBEAA, 0);
        op(0, 0, 24'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 0);
        op(0, 1, 24'h10, 32'h0,        4'h0, 32'hDEADBEAA, 0);

        // Preload words 0..3
        op(0, 0, 24'h0, 32'hCAFE0000, 4'hF, 32'h0, 0);
        op(0, 0, 24'h1, 32'h11111111, 4'hF, 32'h0, 0);
        op(0, 0, 24'h2, 32'h22222222, 4'hF, 32'h0, 0);
        op(0, 0, 24'h3, 32'h33333333, 4'hF, 32'h0, 0);

        // Out-of-range read returns 0 with error; word 0 untouched
        op(0, 1, 24'd4096, 32'h0, 4'h0, 32'h0, 1);
        op(0, 1, 24'h0,    32'h0, 4'h0, 32'hCAFE0000, 0);
        // Out-of-range write: error, DataOut keeps last read data
        op(0, 0, 24'hFFFFFF, 32'h5A5A5A5A, 4'hF, 32'h0, 1);
        op(0, 1, 24'h0,    32'h0, 4'h0, 32'hCAFE0000, 0);

        // Middle-lane merge
        op(0, 0, 24'h20, 32'h01020304, 4'hF, 32'h0, 0);
        op(0, 0, 24'h20, 32'hAABBCCDD, 4'h6, 32'h0, 0);
        op(0, 1, 24'h20, 32'h0,        4'h0, 32'h01BBCC04, 0);

        // Back-to-back reads with MemReq held across Ready
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 24'h1, 32'h0, 4'h0);
        push_exp(0, 1, 32'h11111111, 0);
        wait_ready(0, "b2b1");
        drive(0, 1'b1, 1'b1, 24'h2, 32'h0, 4'h0);
        push_exp(0, 1, 32'h22222222, 0);
        wait_ready(0, "b2b2");
        drive(0, 1'b1, 1'b1, 24'h3, 32'h0, 4'h0);
        push_exp(0, 1, 32'h33333333, 0);
        wait_ready(0, "b2b3");
        drive(0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);

        // Reset mid-BUSY aborts a write to word 5
        op(0, 0, 24'h5, 32'h55AA55AA, 4'hF, 32'h0, 0);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 24'h5, 32'h12345678, 4'hF);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_dout",  bus.DataOut,      32'h0);
        check("midreset_ready", 32'(bus.Ready),   32'd0);
        check("midreset_err",   32'(bus.AddrErr), 32'd0);
        rst = 1'b0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_ready", 32'(bus.Ready), 32'd0);
        end
        op(0, 1, 24'h5, 32'h0, 4'h0, 32'h55AA55AA, 0);

        // Zero-wait-state build
        op(1, 0, 24'h7,    32'h0BADF00D, 4'hF, 32'h0, 0);
        op(1, 1, 24'h7,    32'h0,        4'h0, 32'h0BADF00D, 0);
        op(1, 1, 24'd5000, 32'h0,        4'h0, 32'h0, 1);
        @(negedge clk);
        check("ws0_one_cycle_pulse", 32'(bus0.Ready), 32'd0);

        repeat (4) @(negedge clk);
        check("ws2_queue_empty", 32'(q_exp[0].size()), 32'd0);
        check("ws0_queue_empty", 32'(q_exp[1].size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
